// File: rtl/rf_port_driver.sv
// rf_port_driver: decouples write and read requests from a 3-port register file.
// Writes are queued and drained through a setup/strobe sequence; reads select,
// sample and hand back both source operands with a valid/ready response.
// Optional feature macro: RF_PORT_DRIVER_BYPASS_EN (forward queued write data
// to reads instead of stalling them on a register hazard).
module rf_port_driver #(
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_wr_valid,
    output logic                      out_wr_ready,
    input  logic [4:0]                in_wr_addr,
    input  logic [31:0]               in_wr_data,
    input  logic                      in_rd_valid,
    output logic                      out_rd_ready,
    input  logic [4:0]                in_rd_addr_a,
    input  logic [4:0]                in_rd_addr_b,
    output logic                      out_rsp_valid,
    input  logic                      in_rsp_ready,
    output logic [31:0]               out_rsp_a,
    output logic [31:0]               out_rsp_b,
    output logic [4:0]                out_SA,
    output logic [4:0]                out_SB,
    output logic [4:0]                out_SC,
    output logic [31:0]               out_PC,
    output logic                      out_RFL,
    input  logic [31:0]               in_PA,
    input  logic [31:0]               in_PB,
    output logic [$clog2(WQ_DEPTH):0] out_wq_count
);

    localparam int unsigned AW = $clog2(WQ_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SELECT, R_RESP} rd_state_t;

    logic [RW-1:0] q_addr [WQ_DEPTH];
    logic [DW-1:0] q_data [WQ_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    wr_state_t     wr_state, wr_state_d;
    logic [RW-1:0] sc_d;
    logic [DW-1:0] pc_d;
    logic          rfl_d;
    logic          pop;

    rd_state_t     rd_state, rd_state_d;
    logic [RW-1:0] sa_d, sb_d;
    logic [DW-1:0] rsp_a_d, rsp_b_d;
    logic          rsp_valid_d;

    logic          wr_fire, push, rd_fire;
    logic          hit_a, hit_b;
    logic [AW-1:0] idx;

`ifdef RF_PORT_DRIVER_BYPASS_EN
    logic [DW-1:0] byp_a, byp_b;
    logic          sel_hit_a, sel_hit_b, sel_hit_a_d, sel_hit_b_d;
    logic [DW-1:0] sel_byp_a, sel_byp_b, sel_byp_a_d, sel_byp_b_d;
`endif

    assign out_wr_ready = (count < CW'(WQ_DEPTH));
    assign wr_fire      = in_wr_valid && out_wr_ready;
    assign push         = wr_fire && (in_wr_addr != '0);
    assign out_wq_count = count;

`ifdef RF_PORT_DRIVER_BYPASS_EN
    assign out_rd_ready = (rd_state == R_IDLE);
`else
    assign out_rd_ready = (rd_state == R_IDLE) && !hit_a && !hit_b;
`endif
    assign rd_fire = in_rd_valid && out_rd_ready;

    // Queue pointers and occupancy
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage (contents only meaningful below count)
    always_ff @(posedge in_clk) begin
        if (push) begin
            q_addr[wptr] <= in_wr_addr;
            q_data[wptr] <= in_wr_data;
        end
    end

    // Hazard scan oldest-to-newest so the last match is the newest write
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx   = '0;
`ifdef RF_PORT_DRIVER_BYPASS_EN
        byp_a = '0;
        byp_b = '0;
`endif
        for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            if (CW'(i) < count) begin
                idx = rptr + AW'(i);
                if (q_addr[idx] == in_rd_addr_a) begin
                    hit_a = 1'b1;
`ifdef RF_PORT_DRIVER_BYPASS_EN
                    byp_a = q_data[idx];
`endif
                end
                if (q_addr[idx] == in_rd_addr_b) begin
                    hit_b = 1'b1;
`ifdef RF_PORT_DRIVER_BYPASS_EN
                    byp_b = q_data[idx];
`endif
                end
            end
        end
        if (push && (in_wr_addr == in_rd_addr_a)) begin
            hit_a = 1'b1;
`ifdef RF_PORT_DRIVER_BYPASS_EN
            byp_a = in_wr_data;
`endif
        end
        if (push && (in_wr_addr == in_rd_addr_b)) begin
            hit_b = 1'b1;
`ifdef RF_PORT_DRIVER_BYPASS_EN
            byp_b = in_wr_data;
`endif
        end
        if (in_rd_addr_a == '0) hit_a = 1'b0;
        if (in_rd_addr_b == '0) hit_b = 1'b0;
    end

    // Write FSM state and registered register-file write port
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_state <= W_IDLE;
            out_SC   <= '0;
            out_PC   <= '0;
            out_RFL  <= 1'b0;
        end else begin
            wr_state <= wr_state_d;
            out_SC   <= sc_d;
            out_PC   <= pc_d;
            out_RFL  <= rfl_d;
        end
    end

    // Write FSM: load head, strobe it, pop on strobe exit
    always_comb begin
        wr_state_d = wr_state;
        sc_d       = out_SC;
        pc_d       = out_PC;
        rfl_d      = 1'b0;
        pop        = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (count != '0) begin
                    wr_state_d = W_SETUP;
                    sc_d       = q_addr[rptr];
                    pc_d       = q_data[rptr];
                end
            end
            W_SETUP: begin
                wr_state_d = W_STROBE;
                rfl_d      = 1'b1;
            end
            W_STROBE: begin
                wr_state_d = W_IDLE;
                pop        = 1'b1;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM state and registered response/select outputs
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rd_state      <= R_IDLE;
            out_SA        <= '0;
            out_SB        <= '0;
            out_rsp_a     <= '0;
            out_rsp_b     <= '0;
            out_rsp_valid <= 1'b0;
`ifdef RF_PORT_DRIVER_BYPASS_EN
            sel_hit_a     <= 1'b0;
            sel_hit_b     <= 1'b0;
            sel_byp_a     <= '0;
            sel_byp_b     <= '0;
`endif
        end else begin
            rd_state      <= rd_state_d;
            out_SA        <= sa_d;
            out_SB        <= sb_d;
            out_rsp_a     <= rsp_a_d;
            out_rsp_b     <= rsp_b_d;
            out_rsp_valid <= rsp_valid_d;
`ifdef RF_PORT_DRIVER_BYPASS_EN
            sel_hit_a     <= sel_hit_a_d;
            sel_hit_b     <= sel_hit_b_d;
            sel_byp_a     <= sel_byp_a_d;
            sel_byp_b     <= sel_byp_b_d;
`endif
        end
    end

    // Read FSM: select sources, sample register file, hold until taken
    always_comb begin
        rd_state_d  = rd_state;
        sa_d        = out_SA;
        sb_d        = out_SB;
        rsp_a_d     = out_rsp_a;
        rsp_b_d     = out_rsp_b;
        rsp_valid_d = out_rsp_valid;
`ifdef RF_PORT_DRIVER_BYPASS_EN
        sel_hit_a_d = sel_hit_a;
        sel_hit_b_d = sel_hit_b;
        sel_byp_a_d = sel_byp_a;
        sel_byp_b_d = sel_byp_b;
`endif
        unique case (rd_state)
            R_IDLE: begin
                if (rd_fire) begin
                    rd_state_d  = R_SELECT;
                    sa_d        = in_rd_addr_a;
                    sb_d        = in_rd_addr_b;
`ifdef RF_PORT_DRIVER_BYPASS_EN
                    sel_hit_a_d = hit_a;
                    sel_hit_b_d = hit_b;
                    sel_byp_a_d = byp_a;
                    sel_byp_b_d = byp_b;
`endif
                end
            end
            R_SELECT: begin
                rd_state_d  = R_RESP;
                rsp_valid_d = 1'b1;
`ifdef RF_PORT_DRIVER_BYPASS_EN
                rsp_a_d = sel_hit_a ? sel_byp_a : in_PA;
                rsp_b_d = sel_hit_b ? sel_byp_b : in_PB;
`else
                rsp_a_d = in_PA;
                rsp_b_d = in_PB;
`endif
                if (out_SA == '0) rsp_a_d = '0;
                if (out_SB == '0) rsp_b_d = '0;
            end
            R_RESP: begin
                if (in_rsp_ready) begin
                    rd_state_d  = R_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rf_port_driver.sv
// Bench for rf_port_driver: an architectural register model predicts every
// read response and the order of register-file strobes; monitors compare.
module tb_rf_port_driver;

    localparam int unsigned DEPTH = 4;
`ifdef RF_PORT_DRIVER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_wr_valid, out_wr_ready;
    logic [4:0]  in_wr_addr;
    logic [31:0] in_wr_data;
    logic        in_rd_valid, out_rd_ready;
    logic [4:0]  in_rd_addr_a, in_rd_addr_b;
    logic        out_rsp_valid, in_rsp_ready;
    logic [31:0] out_rsp_a, out_rsp_b;
    logic [4:0]  out_SA, out_SB, out_SC;
    logic [31:0] out_PC;
    logic        out_RFL;
    logic [31:0] in_PA, in_PB;
    logic [2:0]  out_wq_count;

    rf_port_driver #(.WQ_DEPTH(DEPTH)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_wr_valid(in_wr_valid), .out_wr_ready(out_wr_ready),
        .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
        .in_rd_valid(in_rd_valid), .out_rd_ready(out_rd_ready),
        .in_rd_addr_a(in_rd_addr_a), .in_rd_addr_b(in_rd_addr_b),
        .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
        .out_rsp_a(out_rsp_a), .out_rsp_b(out_rsp_b),
        .out_SA(out_SA), .out_SB(out_SB), .out_SC(out_SC),
        .out_PC(out_PC), .out_RFL(out_RFL),
        .in_PA(in_PA), .in_PB(in_PB), .out_wq_count(out_wq_count)
    );

    always #10 in_clk = ~in_clk;

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [31:0] a; logic [31:0] b; int acc; } rsp_t;

    // Register file environment; register 0 reads as garbage on purpose
    logic [31:0] rf   [32];
    logic [31:0] arch [32];
    assign in_PA = (out_SA == 5'd0) ? 32'hDEAD_BEEF : rf[out_SA];
    assign in_PB = (out_SB == 5'd0) ? 32'hBAAD_F00D : rf[out_SB];
    always @(posedge in_clk) if (out_RFL) rf[out_SC] <= out_PC;

    int   cyc = 0;
    always @(posedge in_clk) cyc++;

    int   errors = 0;
    int   checks = 0;
    wr_t  wq[$];
    rsp_t rsp_q[$];
    bit   strobing_now = 1'b0;
    logic [4:0] strobing_addr = '0;
    int   last_strobe = -100;
    bit   rd_busy = 1'b0;
    int   acc_cyc = 0;
    bit   fresh = 1'b1;
    bit   last_wfire, last_rfire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: handshake did not complete within bound", name);
        end
    endtask

    // A register is hazardous while a committed-later write to it is pending
    function automatic bit pending(input logic [4:0] r, input bit wf, input logic [4:0] wa);
        bit h = 1'b0;
        if (r == 5'd0) return 1'b0;
        foreach (wq[i]) if (wq[i].a == r) h = 1'b1;
        if (strobing_now && strobing_addr == r) h = 1'b1;
        if (wf && wa == r) h = 1'b1;
        return h;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_RFL", 32'(out_RFL), 32'd0);
        chk("rst_rsp_valid", 32'(out_rsp_valid), 32'd0);
        chk("rst_wq_count", 32'(out_wq_count), 32'd0);
        chk("rst_SA", 32'(out_SA), 32'd0);
        chk("rst_SB", 32'(out_SB), 32'd0);
        chk("rst_SC", 32'(out_SC), 32'd0);
        chk("rst_PC", out_PC, 32'd0);
        chk("rst_rsp_a", out_rsp_a, 32'd0);
        chk("rst_rsp_b", out_rsp_b, 32'd0);
    endtask

    // One clock of stimulus; the model advances just before the active edge
    task automatic step(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                        input bit rv, input logic [4:0] ra, input logic [4:0] rb,
                        input bit rr);
        int  exp_cnt;
        bit  exp_wrdy, exp_rrdy, wf, rfire;
        @(negedge in_clk);
        in_wr_valid = wv; in_wr_addr = wa; in_wr_data = wd;
        in_rd_valid = rv; in_rd_addr_a = ra; in_rd_addr_b = rb;
        in_rsp_ready = rr;
        #4;
        exp_cnt  = wq.size() + (strobing_now ? 1 : 0);
        exp_wrdy = (exp_cnt < DEPTH);
        chk("wq_count", 32'(out_wq_count), 32'(exp_cnt));
        chk("wr_ready", 32'(out_wr_ready), 32'(exp_wrdy));
        wf = wv && exp_wrdy;
        exp_rrdy = !rd_busy && (BYP || (!pending(ra, wf, wa) && !pending(rb, wf, wa)));
        chk("rd_ready", 32'(out_rd_ready), 32'(exp_rrdy));
        rfire = rv && exp_rrdy;
        if (wf && wa != 5'd0) begin
            arch[wa] = wd;
            wq.push_back('{a: wa, d: wd});
        end
        if (rfire) begin
            rsp_q.push_back('{a: (ra == 5'd0) ? 32'd0 : arch[ra],
                              b: (rb == 5'd0) ? 32'd0 : arch[rb], acc: cyc});
            rd_busy = 1'b1;
            acc_cyc = cyc;
        end else if (rd_busy && cyc >= acc_cyc + 2 && rr) begin
            rd_busy = 1'b0;
        end
        last_wfire = wf;
        last_rfire = rfire;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    endtask

    task automatic wr_until(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        do begin
            step(1'b1, a, d, 1'b0, 5'd0, 5'd0, 1'b1);
            n++;
        end while (!last_wfire && n < 50);
        timeout("wr_accept", last_wfire);
    endtask

    task automatic rd_until(input logic [4:0] a, input logic [4:0] b);
        int n = 0;
        do begin
            step(1'b0, 5'd0, 32'd0, 1'b1, a, b, 1'b1);
            n++;
        end while (!last_rfire && n < 50);
        timeout("rd_accept", last_rfire);
    endtask

    task automatic rand_step();
        step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 7);
    endtask

    // Strobe monitor: each strobe must commit the oldest pending write
    initial begin
        wr_t e;
        forever begin
            @(negedge in_clk);
            #2;
            strobing_now = 1'b0;
            if (in_rst_n && out_RFL) begin
                if (wq.size() == 0) begin
                    chk("unexpected_strobe", 32'(out_RFL), 32'd0);
                end else begin
                    e = wq.pop_front();
                    chk("strobe_SC", 32'(out_SC), 32'(e.a));
                    chk("strobe_PC", out_PC, e.d);
                    chk("strobe_gap_ok", 32'(cyc - last_strobe >= 3), 32'd1);
                    strobing_now  = 1'b1;
                    strobing_addr = e.a;
                    last_strobe   = cyc;
                end
            end
        end
    end

    // Response monitor: data must match the model and stay stable until taken
    initial begin
        rsp_t f;
        forever begin
            @(negedge in_clk);
            #3;
            if (in_rst_n && out_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(out_rsp_valid), 32'd0);
                end else begin
                    f = rsp_q[0];
                    chk("rsp_a", out_rsp_a, f.a);
                    chk("rsp_b", out_rsp_b, f.b);
                    if (fresh) chk("rsp_latency", 32'(cyc), 32'(f.acc + 2));
                    fresh = 1'b0;
                    if (in_rsp_ready) begin
                        void'(rsp_q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin
            rf[i]   = $urandom;
            arch[i] = rf[i];
        end
        in_rst_n = 1'b1;
        in_wr_valid = 1'b0; in_wr_addr = '0; in_wr_data = '0;
        in_rd_valid = 1'b0; in_rd_addr_a = '0; in_rd_addr_b = '0;
        in_rsp_ready = 1'b1;
        #1 in_rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (3) @(negedge in_clk);
        in_rst_n = 1'b1;

        // Basic write then read, including a zero source
        wr_until(5'd4, 32'h4);
        idle(6);
        rd_until(5'd4, 5'd0);
        idle(4);

        // Same-cycle write and dependent read
        step(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd4, 1'b1);
        if (!last_rfire) rd_until(5'd3, 5'd4);
        idle(6);

        // Five back-to-back writes overflow a four-entry queue
        for (int k = 0; k < 5; k++) wr_until(5'(5 + k), $urandom);
        idle(20);

        // Writes to register 0 vanish; reads of it return zero
        wr_until(5'd0, 32'h1234);
        rd_until(5'd0, 5'd0);
        idle(4);

        // Response back-pressure
        rd_until(5'd4, 5'd3);
        repeat (6) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(4);

        repeat (1500) rand_step();

        // Reset in the middle of a strobe
        n = 0;
        do begin
            step(1'b1, 5'(5 + n % 3), $urandom, 1'b0, 5'd0, 5'd0, 1'b1);
            n++;
        end while (!strobing_now && n < 50);
        timeout("reach_strobe", strobing_now);
        in_rst_n = 1'b0;
        #1 chk_reset_outputs();
        wq.delete();
        rsp_q.delete();
        strobing_now = 1'b0;
        rd_busy      = 1'b0;
        fresh        = 1'b1;
        last_strobe  = -100;
        for (int i = 0; i < 32; i++) arch[i] = rf[i];
        idle(2);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        idle(10);

        repeat (500) rand_step();
        idle(40);
        chk("drain_writes", 32'(wq.size()), 32'd0);
        chk("drain_reads", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
